// File: rtl/fixed_float_scheduler.sv
// Round-robin arbiter that shares one fixed-to-float converter between four lanes.
// One operation in flight at a time; a converter that never answers is aborted after TIMEOUT cycles.
module fixed_float_scheduler #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [87:0] req_data,
   output logic [3:0]  req_ready,
   output logic        cvt_enable,
   output logic [21:0] cvt_data,
   input  logic        cvt_done,
   input  logic [31:0] cvt_result,
   output logic        rsp_valid,
   output logic [1:0]  rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_error,
   input  logic        rsp_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    last_grant_reg;
   logic [1:0]    id_reg;
   logic [21:0]   op_reg;
   logic [31:0]   result_reg;
   logic          err_reg;
   logic [CW-1:0] cnt_reg;

   logic [21:0]   lane_data [4];
   logic          grant_found;
   logic [1:0]    grant_idx;
   logic [1:0]    cand;
   logic [3:0]    req_ready_c;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = req_data[22*gi +: 22];
   end

   // Search starts one past the previous winner so every lane gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant_reg;
      cand        = last_grant_reg;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant_reg + 2'(k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      req_ready_c = 4'b0000;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               req_ready_c[grant_idx] = 1'b1;
               state_next             = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (cvt_done || cnt_reg == CNT_LAST)
               state_next = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 2'd3;
         id_reg         <= 2'd0;
         op_reg         <= 22'd0;
         result_reg     <= 32'd0;
         err_reg        <= 1'b0;
         cnt_reg        <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant_found) begin
                  op_reg <= lane_data[grant_idx];
                  id_reg <= grant_idx;
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg + CW'(1);
               // A late done still wins over the abort on the final cycle.
               if (cvt_done) begin
                  result_reg <= cvt_result;
                  err_reg    <= 1'b0;
               end else if (cnt_reg == CNT_LAST) begin
                  result_reg <= 32'd0;
                  err_reg    <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  last_grant_reg <= id_reg;
                  cnt_reg        <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = req_ready_c;
   assign cvt_enable = (state_reg == ISSUE) || (state_reg == WAIT);
   assign cvt_data   = cvt_enable ? op_reg : 22'd0;
   assign rsp_valid  = (state_reg == RESP);
   assign rsp_id     = id_reg;
   assign rsp_result = result_reg;
   assign rsp_error  = err_reg;

endmodule
